// File: rtl/hazard_scoreboard.sv
// ID-stage hazard tracker: load-use, multi-cycle RAW/WAW/structural stalls, multi-cycle writeback port.
// Latency: stall is combinational on the ID inputs, state moves on the issue edge; backpressure is stall holding PC and IF/ID.
module hazard_scoreboard #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic [4:0]  id_dest,
  input  logic        id_mem_read,
  input  logic        id_multicycle,
  output logic        stall,
  output logic        mc_busy,
  output logic        mc_wb_valid,
  output logic [4:0]  mc_wb_addr,
  output logic [31:0] pending_mask
);

  typedef enum logic {IDLE, BUSY} mc_state_t;

  mc_state_t        state;
  logic [CNT_W-1:0] mc_count;
  logic [4:0]       mc_dest;
  logic             ex_load;
  logic [4:0]       ex_load_dest;

  logic id_live;
  logic rs_hit;
  logic rt_hit;
  logic waw_hit;
  logic issue;

  assign mc_busy     = (state == BUSY);
  assign mc_wb_valid = mc_busy && (mc_count == CNT_W'(1)) && (mc_dest != 5'd0);
  assign mc_wb_addr  = mc_dest;

  // A source hits when it matches a load still in EX or the in-flight multi-cycle dest; $0 is exempt.
  always_comb begin
    id_live = id_valid & ~id_flush;
    rs_hit  = id_uses_rs && (id_rs != 5'd0) &&
              ((ex_load && (id_rs == ex_load_dest)) || (mc_busy && (id_rs == mc_dest)));
    rt_hit  = id_uses_rt && (id_rt != 5'd0) &&
              ((ex_load && (id_rt == ex_load_dest)) || (mc_busy && (id_rt == mc_dest)));
    waw_hit = mc_busy && id_reg_write && (id_dest != 5'd0) && (id_dest == mc_dest);
    stall   = id_live && (rs_hit || rt_hit || waw_hit || (mc_busy && id_multicycle));
    issue   = id_live && !stall;
  end

  always_comb begin
    pending_mask = '0;
    if (mc_busy && (mc_dest != 5'd0))
      pending_mask[mc_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_load      <= 1'b0;
      ex_load_dest <= 5'd0;
    end else begin
      ex_load      <= issue && id_mem_read && id_reg_write && (id_dest != 5'd0);
      ex_load_dest <= id_dest;
    end
  end

  // The writeback cycle is the last BUSY cycle; dependants issue one cycle later from the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mc_count <= '0;
      mc_dest  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && id_multicycle) begin
            mc_count <= CNT_W'(MC_LATENCY);
            mc_dest  <= id_dest;
            state    <= BUSY;
          end
        end
        BUSY: begin
          mc_count <= mc_count - CNT_W'(1);
          if (mc_count == CNT_W'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
